// File: rtl/exe_stage.sv
// Execute stage: combinational single-cycle ALU plus an iterative radix-2 restoring
// divider that stalls ID/EXE and earlier stages while it runs.
module exe_stage #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DIV_CYCLES = 16
) (
    input  logic              ei_clk,
    input  logic              ei_rst,
    input  logic [15:0]       ei_instr,
    input  logic [15:0]       ei_pc,
    input  logic [7:0]        ei_alu_opcode,
    input  logic [DATA_W-1:0] ei_op1,
    input  logic [DATA_W-1:0] ei_op2,
    input  logic [3:0]        ei_wreg_addr,
    input  logic [DATA_W-1:0] ei_write_to_mem_data,
    input  logic [1:0]        ei_rwe,
    output logic [15:0]       eo_instr,
    output logic [15:0]       eo_pc,
    output logic [DATA_W-1:0] eo_result,
    output logic [3:0]        eo_wreg_addr,
    output logic [DATA_W-1:0] eo_write_to_mem_data,
    output logic [1:0]        eo_rwe,
    output logic              eo_stall
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [1:0] RWE_IDLE    = 2'b00;
    localparam logic [3:0] REG_INVALID = 4'hF;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_SLL  = 8'h06;
    localparam logic [7:0] OP_SRL  = 8'h07;
    localparam logic [7:0] OP_SRA  = 8'h08;
    localparam logic [7:0] OP_SLT  = 8'h09;
    localparam logic [7:0] OP_SLTU = 8'h0A;
    localparam logic [7:0] OP_PASS = 8'h0B;
    localparam logic [7:0] OP_DIV  = 8'h10;
    localparam logic [7:0] OP_DIVU = 8'h11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic              neg;
    logic              dz;
    logic [15:0]       l_instr;
    logic [15:0]       l_pc;
    logic [3:0]        l_wreg;
    logic [DATA_W-1:0] l_wdata;
    logic [1:0]        l_rwe;

    logic              is_div;
    logic              is_signed;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] q_final;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        sh;

    assign is_div    = (ei_alu_opcode == OP_DIV) || (ei_alu_opcode == OP_DIVU);
    assign is_signed = (ei_alu_opcode == OP_DIV);
    assign mag1      = (is_signed && ei_op1[DATA_W-1]) ? DATA_W'(-ei_op1) : ei_op1;
    assign mag2      = (is_signed && ei_op2[DATA_W-1]) ? DATA_W'(-ei_op2) : ei_op2;

    // One restoring step: shift in next dividend bit, trial-subtract divisor
    assign rem_sh  = {rem[DATA_W-1:0], quo[DATA_W-1]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign q_final = dz ? {DATA_W{1'b1}} : (neg ? DATA_W'(-quo) : quo);

    assign sh = ei_op2[3:0];

    always_comb begin
        alu_res = '0;
        case (ei_alu_opcode)
            OP_NOP:  alu_res = '0;
            OP_ADD:  alu_res = DATA_W'(ei_op1 + ei_op2);
            OP_SUB:  alu_res = DATA_W'(ei_op1 - ei_op2);
            OP_AND:  alu_res = ei_op1 & ei_op2;
            OP_OR:   alu_res = ei_op1 | ei_op2;
            OP_XOR:  alu_res = ei_op1 ^ ei_op2;
            OP_SLL:  alu_res = ei_op1 << sh;
            OP_SRL:  alu_res = ei_op1 >> sh;
            OP_SRA:  alu_res = DATA_W'($signed(ei_op1) >>> sh);
            OP_SLT:  alu_res = DATA_W'($signed(ei_op1) < $signed(ei_op2));
            OP_SLTU: alu_res = DATA_W'(ei_op1 < ei_op2);
            OP_PASS: alu_res = ei_op1;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge ei_clk) begin
        if (ei_rst) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (is_div) state_nx = S_BUSY;
            S_BUSY:  if (cnt == CNT_W'(1)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Divider datapath and latched pass-through fields
    always_ff @(posedge ei_clk) begin
        if (ei_rst) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg     <= 1'b0;
            dz      <= 1'b0;
            l_instr <= '0;
            l_pc    <= '0;
            l_wreg  <= REG_INVALID;
            l_wdata <= '0;
            l_rwe   <= RWE_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_div) begin
                        cnt     <= CNT_W'(DIV_CYCLES);
                        rem     <= '0;
                        quo     <= mag1;
                        dvs     <= mag2;
                        neg     <= is_signed && (ei_op1[DATA_W-1] ^ ei_op2[DATA_W-1]);
                        dz      <= (ei_op2 == '0);
                        l_instr <= ei_instr;
                        l_pc    <= ei_pc;
                        l_wreg  <= ei_wreg_addr;
                        l_wdata <= ei_write_to_mem_data;
                        l_rwe   <= ei_rwe;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (!diff[DATA_W]) begin
                        rem <= diff;
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        eo_instr             = '0;
        eo_pc                = '0;
        eo_result            = '0;
        eo_wreg_addr         = REG_INVALID;
        eo_write_to_mem_data = '0;
        eo_rwe               = RWE_IDLE;
        eo_stall             = 1'b0;
        if (!ei_rst) begin
            case (state)
                S_IDLE: begin
                    if (is_div) begin
                        eo_stall = 1'b1;
                    end else begin
                        eo_instr             = ei_instr;
                        eo_pc                = ei_pc;
                        eo_result            = alu_res;
                        eo_wreg_addr         = ei_wreg_addr;
                        eo_write_to_mem_data = ei_write_to_mem_data;
                        eo_rwe               = ei_rwe;
                    end
                end
                S_BUSY: eo_stall = 1'b1;
                S_DONE: begin
                    eo_instr             = l_instr;
                    eo_pc                = l_pc;
                    eo_result            = q_final;
                    eo_wreg_addr         = l_wreg;
                    eo_write_to_mem_data = l_wdata;
                    eo_rwe               = l_rwe;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: reset bubble, ALU sweep, divide latency/results,
// reset during a divide and back-to-back divides.
module tb_exe_stage;

    logic        ei_clk;
    logic        ei_rst;
    logic [15:0] ei_instr;
    logic [15:0] ei_pc;
    logic [7:0]  ei_alu_opcode;
    logic [15:0] ei_op1;
    logic [15:0] ei_op2;
    logic [3:0]  ei_wreg_addr;
    logic [15:0] ei_write_to_mem_data;
    logic [1:0]  ei_rwe;
    logic [15:0] eo_instr;
    logic [15:0] eo_pc;
    logic [15:0] eo_result;
    logic [3:0]  eo_wreg_addr;
    logic [15:0] eo_write_to_mem_data;
    logic [1:0]  eo_rwe;
    logic        eo_stall;

    int checks = 0;
    int errors = 0;

    exe_stage dut (
        .ei_clk               (ei_clk),
        .ei_rst               (ei_rst),
        .ei_instr             (ei_instr),
        .ei_pc                (ei_pc),
        .ei_alu_opcode        (ei_alu_opcode),
        .ei_op1               (ei_op1),
        .ei_op2               (ei_op2),
        .ei_wreg_addr         (ei_wreg_addr),
        .ei_write_to_mem_data (ei_write_to_mem_data),
        .ei_rwe               (ei_rwe),
        .eo_instr             (eo_instr),
        .eo_pc                (eo_pc),
        .eo_result            (eo_result),
        .eo_wreg_addr         (eo_wreg_addr),
        .eo_write_to_mem_data (eo_write_to_mem_data),
        .eo_rwe               (eo_rwe),
        .eo_stall             (eo_stall)
    );

    initial ei_clk = 1'b0;
    always #5 ei_clk = ~ei_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] pc);
        ei_alu_opcode        = op;
        ei_op1               = a;
        ei_op2               = b;
        ei_pc                = pc;
        ei_instr             = pc ^ 16'h5A00;
        ei_wreg_addr         = pc[3:0] ^ 4'h3;
        ei_write_to_mem_data = pc + 16'h1111;
        ei_rwe               = 2'b01;
    endtask

    task automatic alu(input string tag, input logic [7:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp);
        @(posedge ei_clk); #1;
        drive(op, a, b, 16'h0040);
        @(negedge ei_clk);
        chk(tag, eo_result, exp);
    endtask

    // Issue a divide and watch the whole stall window; optionally rewrite the
    // ID/EXE inputs to a second divide (nop2/pc2) while the first is busy.
    task automatic run_div(input string tag, input logic [7:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] pc,
                           input logic [15:0] exp, input logic scramble,
                           input logic [7:0] op2n, input logic [15:0] a2,
                           input logic [15:0] b2, input logic [15:0] pc2);
        int  n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        @(posedge ei_clk); #1;
        drive(op, a, b, pc);
        @(negedge ei_clk);
        while (eo_stall && n < 40) begin
            if (eo_result !== 16'h0 || eo_pc !== 16'h0 || eo_instr !== 16'h0 ||
                eo_wreg_addr !== 4'hF || eo_rwe !== 2'b00 || eo_write_to_mem_data !== 16'h0)
                bad = 1'b1;
            n++;
            if (scramble && n == 3) drive(op2n, a2, b2, pc2);
            @(negedge ei_clk);
        end
        chk({tag, "_stall_cycles"}, 16'(n), 16'd17);
        chk({tag, "_bubble"}, 16'(bad), 16'd0);
        chk({tag, "_result"}, eo_result, exp);
        chk({tag, "_pc"}, eo_pc, pc);
        chk({tag, "_wreg"}, 16'(eo_wreg_addr), 16'(pc[3:0] ^ 4'h3));
        chk({tag, "_wdata"}, eo_write_to_mem_data, pc + 16'h1111);
        chk({tag, "_rwe"}, 16'(eo_rwe), 16'd1);
        chk({tag, "_done_stall"}, 16'(eo_stall), 16'd0);
    endtask

    initial begin
        ei_rst = 1'b1;
        drive(8'h01, 16'h0003, 16'h0004, 16'h0010);

        // Reset with ADD inputs present: bubble
        @(negedge ei_clk);
        chk("rst_instr", eo_instr, 16'h0);
        chk("rst_pc", eo_pc, 16'h0);
        chk("rst_result", eo_result, 16'h0);
        chk("rst_wreg", 16'(eo_wreg_addr), 16'h000F);
        chk("rst_wdata", eo_write_to_mem_data, 16'h0);
        chk("rst_rwe", 16'(eo_rwe), 16'h0);
        chk("rst_stall", 16'(eo_stall), 16'h0);
        repeat (2) @(posedge ei_clk);
        #1 ei_rst = 1'b0;
        @(negedge ei_clk);
        chk("add_result", eo_result, 16'h0007);
        chk("add_pc", eo_pc, 16'h0010);
        chk("add_instr", eo_instr, 16'h5A10);
        chk("add_stall", 16'(eo_stall), 16'h0);

        // ALU sweep
        alu("sub", 8'h02, 16'h0000, 16'h0001, 16'hFFFF);
        alu("and", 8'h03, 16'hF0F0, 16'h3C3C, 16'h3030);
        alu("or", 8'h04, 16'hF0F0, 16'h0F01, 16'hFFF1);
        alu("xor", 8'h05, 16'hFF00, 16'h0FF0, 16'hF0F0);
        alu("sll", 8'h06, 16'h0001, 16'h0013, 16'h0008);
        alu("srl", 8'h07, 16'h8000, 16'h0004, 16'h0800);
        alu("sra", 8'h08, 16'h8000, 16'h0004, 16'hF800);
        alu("slt", 8'h09, 16'hFFFF, 16'h0001, 16'h0001);
        alu("sltu", 8'h0A, 16'hFFFF, 16'h0001, 16'h0000);
        alu("pass", 8'h0B, 16'hBEEF, 16'h1234, 16'hBEEF);
        alu("nop", 8'h00, 16'h1234, 16'h1234, 16'h0000);
        alu("unknown", 8'h7F, 16'h1234, 16'h0001, 16'h0000);

        // Divides with ID/EXE held
        run_div("divu", 8'h11, 16'h0064, 16'h0007, 16'h0100, 16'h000E, 1'b0, 8'h0, 16'h0, 16'h0, 16'h0);
        alu("after_divu", 8'h01, 16'h0001, 16'h0002, 16'h0003);
        run_div("div_neg", 8'h10, 16'hFF9C, 16'h0007, 16'h0104, 16'hFFF2, 1'b0, 8'h0, 16'h0, 16'h0, 16'h0);
        alu("gap1", 8'h00, 16'h0, 16'h0, 16'h0);
        run_div("div_wrap", 8'h10, 16'h8000, 16'hFFFF, 16'h0108, 16'h8000, 1'b0, 8'h0, 16'h0, 16'h0, 16'h0);
        alu("gap2", 8'h00, 16'h0, 16'h0, 16'h0);
        run_div("div_zero", 8'h10, 16'h1234, 16'h0000, 16'h010C, 16'hFFFF, 1'b0, 8'h0, 16'h0, 16'h0, 16'h0);
        alu("gap3", 8'h00, 16'h0, 16'h0, 16'h0);
        run_div("divu_zero", 8'h11, 16'h0005, 16'h0000, 16'h0110, 16'hFFFF, 1'b0, 8'h0, 16'h0, 16'h0, 16'h0);
        alu("gap4", 8'h00, 16'h0, 16'h0, 16'h0);

        // Reset at BUSY cycle 8 aborts the divide
        @(posedge ei_clk); #1;
        drive(8'h11, 16'h0064, 16'h0007, 16'h0120);
        @(negedge ei_clk);
        chk("abort_issue_stall", 16'(eo_stall), 16'h1);
        repeat (8) @(negedge ei_clk);
        chk("abort_busy_stall", 16'(eo_stall), 16'h1);
        @(posedge ei_clk); #1;
        ei_rst = 1'b1;
        drive(8'h01, 16'h0003, 16'h0004, 16'h0130);
        @(negedge ei_clk);
        chk("abort_rst_stall", 16'(eo_stall), 16'h0);
        chk("abort_rst_result", eo_result, 16'h0);
        chk("abort_rst_pc", eo_pc, 16'h0);
        @(posedge ei_clk); #1 ei_rst = 1'b0;
        @(negedge ei_clk);
        chk("abort_add_result", eo_result, 16'h0007);
        chk("abort_add_stall", 16'(eo_stall), 16'h0);
        @(negedge ei_clk);
        chk("abort_add2_result", eo_result, 16'h0007);
        chk("abort_add2_pc", eo_pc, 16'h0130);
        chk("abort_add2_stall", 16'(eo_stall), 16'h0);

        // Back-to-back divides; second one's inputs appear during the first's BUSY
        run_div("b2b_first", 8'h11, 16'h0064, 16'h0007, 16'h0200, 16'h000E, 1'b1,
                8'h11, 16'h00C8, 16'h000A, 16'h0300);
        run_div("b2b_second", 8'h11, 16'h00C8, 16'h000A, 16'h0300, 16'h0014, 1'b0,
                8'h0, 16'h0, 16'h0, 16'h0);
        alu("final_add", 8'h01, 16'h1000, 16'h0234, 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
